ama_riscv_alu_arb: RTL and testbench

//  Shares one combinational ama_riscv ALU between two requesters (r0: main EX path, r1: aux unit,
//  e.g. AGU/CSR helper). Per-requester valid/ready request and response channels; single-entry

---
 rtl/ama_riscv_alu_arb.sv | 153 +++++++++++++++
 tb/tb_ama_riscv_alu_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_alu_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_alu_arb
//  Purpose  : Shares one combinational ALU between two requesters (r0: main
//             EX path, r1: auxiliary unit). Each requester has valid/ready
//             request and response channels. A single-entry operand stage
//             drives the ALU. Arbitration is round-robin or fixed priority,
//             and each requester has a saturating grant counter.
//  Revision : 1.0  initial release
// ============================================================================
module ama_riscv_alu_arb #(
    parameter int              RR_EN      = 1,   // 1: round-robin, 0: r0 always wins
    parameter int              CNT_W      = 16,  // grant counter width
    parameter int              ARCH_W     = 32,  // operand / result width
    parameter int              OP_W       = 4,   // ALU opcode width
    parameter logic [OP_W-1:0] ALU_OP_OFF = '0   // opcode driven when ALU is idle
) (
    input  logic              clk,
    input  logic              rst_n,

    // requester 0
    input  logic              r0_req_valid_i,
    output logic              r0_req_ready_o,
    input  logic [OP_W-1:0]   r0_op_i,
    input  logic [ARCH_W-1:0] r0_a_i,
    input  logic [ARCH_W-1:0] r0_b_i,
    output logic              r0_rsp_valid_o,
    input  logic              r0_rsp_ready_i,
    output logic [ARCH_W-1:0] r0_rsp_s_o,

    // requester 1
    input  logic              r1_req_valid_i,
    output logic              r1_req_ready_o,
    input  logic [OP_W-1:0]   r1_op_i,
    input  logic [ARCH_W-1:0] r1_a_i,
    input  logic [ARCH_W-1:0] r1_b_i,
    output logic              r1_rsp_valid_o,
    input  logic              r1_rsp_ready_i,
    output logic [ARCH_W-1:0] r1_rsp_s_o,

    // shared ALU
    output logic [OP_W-1:0]   alu_op_o,
    output logic [ARCH_W-1:0] alu_a_o,
    output logic [ARCH_W-1:0] alu_b_o,
    input  logic [ARCH_W-1:0] alu_s_i,

    // grant statistics
    output logic [CNT_W-1:0]  r0_grant_cnt_o,
    output logic [CNT_W-1:0]  r1_grant_cnt_o
);

    localparam logic             RR      = (RR_EN != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // operand stage and arbitration state
    logic              stg_vld_q;
    logic              stg_own_q;
    logic [OP_W-1:0]   stg_op_q;
    logic [ARCH_W-1:0] stg_a_q;
    logic [ARCH_W-1:0] stg_b_q;
    logic              rr_ptr_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              w_own_rsp_rdy;
    logic              w_drain;
    logic              w_free;
    logic              w_any;
    logic              w_gnt;
    logic              w_acc;
    logic [OP_W-1:0]   w_acc_op;
    logic [ARCH_W-1:0] w_acc_a;
    logic [ARCH_W-1:0] w_acc_b;

    // Arbitration: only the current owner's rsp_ready can free the stage, so
    // the non-owner's rsp_ready never influences request acceptance.
    always_comb begin
        w_own_rsp_rdy = stg_own_q ? r1_rsp_ready_i : r0_rsp_ready_i;
        w_drain       = stg_vld_q & w_own_rsp_rdy;
        w_free        = ~stg_vld_q | w_drain;
        w_any         = r0_req_valid_i | r1_req_valid_i;
        if (r0_req_valid_i && r1_req_valid_i) begin
            w_gnt = RR ? rr_ptr_q : 1'b0;
        end else begin
            w_gnt = r1_req_valid_i;
        end
        // rst_n gating keeps both readies low while reset is asserted
        w_acc          = w_free & w_any & rst_n;
        r0_req_ready_o = w_acc & ~w_gnt;
        r1_req_ready_o = w_acc &  w_gnt;
        w_acc_op       = w_gnt ? r1_op_i : r0_op_i;
        w_acc_a        = w_gnt ? r1_a_i  : r0_a_i;
        w_acc_b        = w_gnt ? r1_b_i  : r0_b_i;
    end

    // Operand stage: load on accept, empty on drain without a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_q <= 1'b0;
            stg_own_q <= 1'b0;
            stg_op_q  <= ALU_OP_OFF;
            stg_a_q   <= '0;
            stg_b_q   <= '0;
        end else if (w_acc) begin
            stg_vld_q <= 1'b1;
            stg_own_q <= w_gnt;
            stg_op_q  <= w_acc_op;
            stg_a_q   <= w_acc_a;
            stg_b_q   <= w_acc_b;
        end else if (w_drain) begin
            stg_vld_q <= 1'b0;
        end
    end

    // Round-robin pointer prefers the requester that was not just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (RR && w_acc) begin
            rr_ptr_q <= ~w_gnt;
        end
    end

    // Saturating grant counters, one per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (w_acc && !w_gnt && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (w_acc && w_gnt && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    // Outputs: ALU inputs are quiet when idle, results are zero unless valid.
    always_comb begin
        alu_op_o       = stg_vld_q ? stg_op_q : ALU_OP_OFF;
        alu_a_o        = stg_vld_q ? stg_a_q  : '0;
        alu_b_o        = stg_vld_q ? stg_b_q  : '0;
        r0_rsp_valid_o = stg_vld_q & ~stg_own_q;
        r1_rsp_valid_o = stg_vld_q &  stg_own_q;
        r0_rsp_s_o     = r0_rsp_valid_o ? alu_s_i : '0;
        r1_rsp_s_o     = r1_rsp_valid_o ? alu_s_i : '0;
        r0_grant_cnt_o = cnt0_q;
        r1_grant_cnt_o = cnt1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_alu_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ama_riscv_alu_arb
//  Purpose  : Self-checking bench for ama_riscv_alu_arb. Two instances share
//             the same stimulus: index 0 is round-robin with 16-bit counters,
//             index 1 is fixed priority with 4-bit counters. A transaction
//             level model predicts every output each cycle; directed
//             sequences pin the model with hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ama_riscv_alu_arb;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0, v1, rr0, rr1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;

    logic        rq_rdy0 [2];
    logic        rq_rdy1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic [31:0] rs0 [2];
    logic [31:0] rs1 [2];
    logic [3:0]  aop [2];
    logic [31:0] aa [2];
    logic [31:0] ab [2];
    logic [31:0] as_ [2];
    logic [15:0] c0a, c1a;
    logic [3:0]  c0b, c1b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // reference ALU (unknown opcodes return 0)
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a << b[4:0];
            4'd4:    return {31'b0, $signed(a) < $signed(b)};
            4'd5:    return {31'b0, a < b};
            4'd6:    return a ^ b;
            4'd7:    return a >> b[4:0];
            4'd8:    return $signed(a) >>> b[4:0];
            4'd9:    return a | b;
            4'd10:   return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign as_[0] = alu_fn(aop[0], aa[0], ab[0]);
    assign as_[1] = alu_fn(aop[1], aa[1], ab[1]);

    ama_riscv_alu_arb #(.RR_EN(1), .CNT_W(16)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid_i(v0), .r0_req_ready_o(rq_rdy0[0]), .r0_op_i(op0), .r0_a_i(a0), .r0_b_i(b0),
        .r0_rsp_valid_o(rv0[0]), .r0_rsp_ready_i(rr0), .r0_rsp_s_o(rs0[0]),
        .r1_req_valid_i(v1), .r1_req_ready_o(rq_rdy1[0]), .r1_op_i(op1), .r1_a_i(a1), .r1_b_i(b1),
        .r1_rsp_valid_o(rv1[0]), .r1_rsp_ready_i(rr1), .r1_rsp_s_o(rs1[0]),
        .alu_op_o(aop[0]), .alu_a_o(aa[0]), .alu_b_o(ab[0]), .alu_s_i(as_[0]),
        .r0_grant_cnt_o(c0a), .r1_grant_cnt_o(c1a)
    );

    ama_riscv_alu_arb #(.RR_EN(0), .CNT_W(4)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid_i(v0), .r0_req_ready_o(rq_rdy0[1]), .r0_op_i(op0), .r0_a_i(a0), .r0_b_i(b0),
        .r0_rsp_valid_o(rv0[1]), .r0_rsp_ready_i(rr0), .r0_rsp_s_o(rs0[1]),
        .r1_req_valid_i(v1), .r1_req_ready_o(rq_rdy1[1]), .r1_op_i(op1), .r1_a_i(a1), .r1_b_i(b1),
        .r1_rsp_valid_o(rv1[1]), .r1_rsp_ready_i(rr1), .r1_rsp_s_o(rs1[1]),
        .alu_op_o(aop[1]), .alu_a_o(aa[1]), .alu_b_o(ab[1]), .alu_s_i(as_[1]),
        .r0_grant_cnt_o(c0b), .r1_grant_cnt_o(c1b)
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: one pending result per instance, owner,
    // preferred requester and grant totals. Checked every falling edge.
    // ------------------------------------------------------------------
    bit          m_have [2];
    bit          m_own  [2];
    bit          m_pref [2];
    logic [3:0]  m_op   [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    int          m_cnt  [2][2];
    int          cmax   [2] = '{65535, 15};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] act_c0, act_c1, res;
            bit          own_rdy, free, win, any;
            act_c0 = (d == 0) ? {16'b0, c0a} : {28'b0, c0b};
            act_c1 = (d == 0) ? {16'b0, c1a} : {28'b0, c1b};
            if (!rst_n) begin
                chk("rst_req_ready0", d, rq_rdy0[d], 0);
                chk("rst_req_ready1", d, rq_rdy1[d], 0);
                chk("rst_rsp_valid0", d, rv0[d], 0);
                chk("rst_rsp_valid1", d, rv1[d], 0);
                chk("rst_alu_op", d, aop[d], 0);
                chk("rst_cnt0", d, act_c0, 0);
                m_have[d] = 0; m_own[d] = 0; m_pref[d] = 0;
                m_cnt[d][0] = 0; m_cnt[d][1] = 0;
            end else begin
                own_rdy = m_own[d] ? rr1 : rr0;
                free    = !m_have[d] || own_rdy;
                any     = v0 || v1;
                win     = (v0 && v1) ? ((d == 0) ? m_pref[d] : 1'b0) : v1;
                res     = alu_fn(m_op[d], m_a[d], m_b[d]);
                chk("req_ready0", d, rq_rdy0[d], free && any && !win);
                chk("req_ready1", d, rq_rdy1[d], free && any && win);
                chk("rsp_valid0", d, rv0[d], m_have[d] && !m_own[d]);
                chk("rsp_valid1", d, rv1[d], m_have[d] && m_own[d]);
                chk("rsp_s0", d, rs0[d], (m_have[d] && !m_own[d]) ? res : 32'd0);
                chk("rsp_s1", d, rs1[d], (m_have[d] && m_own[d]) ? res : 32'd0);
                chk("alu_op", d, aop[d], m_have[d] ? m_op[d] : 4'd0);
                chk("alu_a", d, aa[d], m_have[d] ? m_a[d] : 32'd0);
                chk("alu_b", d, ab[d], m_have[d] ? m_b[d] : 32'd0);
                chk("grant_cnt0", d, act_c0, m_cnt[d][0]);
                chk("grant_cnt1", d, act_c1, m_cnt[d][1]);
                if (free) m_have[d] = 0;
                if (free && any) begin
                    m_have[d] = 1;
                    m_own[d]  = win;
                    m_op[d]   = win ? op1 : op0;
                    m_a[d]    = win ? a1 : a0;
                    m_b[d]    = win ? b1 : b0;
                    if (m_cnt[d][win] < cmax[d]) m_cnt[d][win]++;
                    if (d == 0) m_pref[d] = !win;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: directed sequences with literal expectations, then random
    // ------------------------------------------------------------------
    initial begin
        bit prev, g;
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) step();
        @(negedge clk);
        chk("lit_reset_alu_op", 0, aop[0], 0);
        step();
        rst_n = 1;

        // single r0 ADD 5+7
        v0 = 1; op0 = OP_ADD; a0 = 5; b0 = 7;
        @(negedge clk);
        chk("lit_add_ready", 0, rq_rdy0[0], 1);
        step();
        v0 = 0;
        @(negedge clk);
        chk("lit_add_rsp_valid", 0, rv0[0], 1);
        chk("lit_add_rsp_s", 0, rs0[0], 12);
        chk("lit_add_r1_valid", 0, rv1[0], 0);
        step();

        // contention: round-robin alternates, fixed priority always r0
        v0 = 1; op0 = OP_SUB;  a0 = 10; b0 = 3;
        v1 = 1; op1 = OP_SLTU; a1 = 1;  b1 = 2;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g = rq_rdy1[0];
            chk("lit_rr_one_ready", 0, rq_rdy0[0] ^ rq_rdy1[0], 1);
            if (i > 0) begin
                chk("lit_rr_alternate", 0, g, !prev);
                chk("lit_rr_rsp_valid", 0, prev ? rv1[0] : rv0[0], 1);
                chk("lit_rr_rsp_s", 0, prev ? rs1[0] : rs0[0], prev ? 32'd1 : 32'd7);
            end
            chk("lit_fp_r0_ready", 1, rq_rdy0[1], 1);
            chk("lit_fp_r1_ready", 1, rq_rdy1[1], 0);
            prev = g;
            step();
        end
        v0 = 0;
        @(negedge clk);
        chk("lit_fp_r1_after_r0", 1, rq_rdy1[1], 1);
        step();
        v1 = 0;
        step();

        // backpressure: r1 SLL 1<<4 held while r1_rsp_ready=0
        rr1 = 0; v1 = 1; op1 = OP_SLL; a1 = 1; b1 = 4;
        @(negedge clk);
        chk("lit_bp_accept", 0, rq_rdy1[0], 1);
        step();
        v1 = 0; v0 = 1; op0 = OP_ADD; a0 = 2; b0 = 3;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("lit_bp_rsp_valid", d, rv1[d], 1);
                chk("lit_bp_rsp_s", d, rs1[d], 16);
                chk("lit_bp_r0_blocked", d, rq_rdy0[d], 0);
            end
            step();
        end
        rr1 = 1;
        @(negedge clk);
        chk("lit_bp_r0_granted", 0, rq_rdy0[0], 1);
        step();
        v0 = 0;
        repeat (2) step();

        // reset while an op is held in the stage
        rr0 = 0; v0 = 1; op0 = OP_XOR; a0 = 32'hF0F0; b0 = 32'h0FF0;
        step();
        v0 = 0;
        @(negedge clk);
        chk("lit_mid_pre_valid", 0, rv0[0], 1);
        step();
        rst_n = 0;
        #1;
        chk("lit_mid_rsp_valid", 0, rv0[0], 0);
        chk("lit_mid_alu_op", 0, aop[0], 0);
        chk("lit_mid_cnt0", 0, {16'b0, c0a}, 0);
        step();
        rr0 = 1; v0 = 1; v1 = 1; op0 = OP_ADD; a0 = 1; b0 = 1; op1 = OP_ADD; a1 = 2; b1 = 2;
        rst_n = 1;
        @(negedge clk);
        chk("lit_post_rst_r0", 0, rq_rdy0[0], 1);
        chk("lit_post_rst_r1", 0, rq_rdy1[0], 0);
        step();
        v1 = 0;

        // counter saturation: 21 r0 accepts in total
        repeat (20) step();
        v0 = 0;
        @(negedge clk);
        chk("lit_sat_cnt0", 1, {28'b0, c0b}, 15);
        chk("lit_sat_cnt1", 1, {28'b0, c1b}, 0);
        chk("lit_cnt0_16b", 0, {16'b0, c0a}, 21);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v0  = ($urandom % 4) != 0;
            v1  = ($urandom % 3) != 0;
            rr0 = ($urandom % 4) != 0;
            rr1 = ($urandom % 4) != 0;
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            a0  = $urandom;
            a1  = $urandom;
            b0  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
            b1  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
            rst_n = ($urandom % 400) != 0;
            step();
        end
        rst_n = 1; v0 = 0; v1 = 0;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
